time_set_entry: RTL and testbench

//   Button-driven time-entry controller that feeds the alarm clock's set interface.
//   - Preloads four BCD digits from the running clock's binary hour/minute.
//   - User edits the digits with buttons; each digit is range-checked.
//   - On confirm, drives hour1/hour0/minute1/minute0 and a one-cycle set pulse to the clock.

---
 rtl/time_set_pkg.sv | 52 +++++
 rtl/time_set_entry_btn_edge_det.sv | 27 ++
 rtl/time_set_entry.sv | 160 ++++++++++++++++
 tb/tb_time_set_entry.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/time_set_pkg.sv
// Shared types, digit limits and BCD helpers for the time-entry controller.
package time_set_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EDIT_H1 = 3'd1,
    ST_EDIT_H0 = 3'd2,
    ST_EDIT_M1 = 3'd3,
    ST_EDIT_M0 = 3'd4,
    ST_COMMIT  = 3'd5
  } state_e;

  localparam logic [3:0] H1_MAX    = 4'd2;
  localparam logic [3:0] H0_MAX    = 4'd9;
  localparam logic [3:0] H0_MAX_20 = 4'd3;
  localparam logic [3:0] M1_MAX    = 4'd5;
  localparam logic [3:0] M0_MAX    = 4'd9;

  localparam logic [5:0] HOUR_LAST   = 6'd23;
  localparam logic [5:0] MINUTE_LAST = 6'd59;

  // Binary 0..63 to {tens, units} BCD using a compare chain (no divider).
  function automatic logic [7:0] bin2bcd2(input logic [5:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    if (v >= 6'd60) begin
      tens = 4'd6; units = 4'(v - 6'd60);
    end else if (v >= 6'd50) begin
      tens = 4'd5; units = 4'(v - 6'd50);
    end else if (v >= 6'd40) begin
      tens = 4'd4; units = 4'(v - 6'd40);
    end else if (v >= 6'd30) begin
      tens = 4'd3; units = 4'(v - 6'd30);
    end else if (v >= 6'd20) begin
      tens = 4'd2; units = 4'(v - 6'd20);
    end else if (v >= 6'd10) begin
      tens = 4'd1; units = 4'(v - 6'd10);
    end else begin
      tens = 4'd0; units = v[3:0];
    end
    return {tens, units};
  endfunction

  // One wrapping step of a digit within 0..max.
  function automatic logic [3:0] step_digit(input logic [3:0] v,
                                            input logic [3:0] max,
                                            input logic       up);
    if (up) return (v >= max) ? 4'd0 : v + 4'd1;
    else    return (v == 4'd0) ? max : v - 4'd1;
  endfunction

endpackage

// File: rtl/time_set_entry_btn_edge_det.sv
// Rising-edge detector for a vector of debounced button levels.
module btn_edge_det #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] lvl,
  output logic [N-1:0] rise
);

  logic [N-1:0] prev_q;
  logic [N-1:0] prev_d;

  // Next previous-level value is simply the current level.
  always_comb begin
    prev_d = lvl;
  end

  // Register the previous button levels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev_q <= '0;
    else      prev_q <= prev_d;
  end

  assign rise = lvl & ~prev_q;

endmodule

// File: rtl/time_set_entry.sv
// Button-driven time-entry controller feeding the alarm clock set interface.
// Optional edit timeout is enabled by defining SET_TIMEOUT_EN.
module time_set_entry
  import time_set_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000,
  parameter int unsigned TO_W           = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_enter,
  input  logic       btn_next,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [5:0] cur_hour,
  input  logic [5:0] cur_minute,
  output logic [3:0] hour1,
  output logic [3:0] hour0,
  output logic [3:0] minute1,
  output logic [3:0] minute0,
  output logic       set,
  output logic       editing,
  output logic [1:0] digit_sel
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [3:0] rise;
  logic       ev_enter, ev_next, ev_inc, ev_dec;
  logic       to_hit;

  state_e     state_q, state_d;
  logic [3:0] h1_q, h1_d, h0_q, h0_d, m1_q, m1_d, m0_q, m0_d;
  logic       set_q, set_d;
  logic       editing_q, editing_d;
  logic [1:0] sel_q, sel_d;
  logic [7:0] hour_bcd, min_bcd;
  logic [3:0] h0_max;

  btn_edge_det #(.N(4)) u_edge (
    .clk  (clk),
    .rst  (rst),
    .lvl  ({btn_dec, btn_inc, btn_next, btn_enter}),
    .rise (rise)
  );

  assign ev_enter = rise[0];
  assign ev_next  = rise[1];
  assign ev_inc   = rise[2];
  assign ev_dec   = rise[3];

`ifdef SET_TIMEOUT_EN
  logic [TO_W-1:0] to_q, to_d;
  logic            in_edit;

  // Idle-cycle counter for edit abort; restarts on any button edge.
  always_comb begin
    in_edit = state_q inside {ST_EDIT_H1, ST_EDIT_H0, ST_EDIT_M1, ST_EDIT_M0};
    to_hit  = in_edit && (rise == 4'b0000) && (to_q == TO_LAST);
    to_d    = '0;
    if (in_edit && (rise == 4'b0000) && !to_hit) to_d = to_q + 1'b1;
  end

  // Timeout counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) to_q <= '0;
    else      to_q <= to_d;
  end
`else
  logic unused_to_last;
  assign to_hit         = 1'b0;
  assign unused_to_last = ^TO_LAST;
`endif

  // Next-state, digit editing and registered output computation.
  always_comb begin
    state_d  = state_q;
    h1_d     = h1_q;
    h0_d     = h0_q;
    m1_d     = m1_q;
    m0_d     = m0_q;
    sel_d    = sel_q;
    set_d    = 1'b0;
    hour_bcd = bin2bcd2((cur_hour > HOUR_LAST) ? 6'd0 : cur_hour);
    min_bcd  = bin2bcd2((cur_minute > MINUTE_LAST) ? 6'd0 : cur_minute);
    h0_max   = (h1_q == H1_MAX) ? H0_MAX_20 : H0_MAX;
    case (state_q)
      ST_IDLE: begin
        if (ev_enter) begin
          state_d      = ST_EDIT_H1;
          sel_d        = 2'd0;
          {h1_d, h0_d} = hour_bcd;
          {m1_d, m0_d} = min_bcd;
        end
      end
      ST_EDIT_H1, ST_EDIT_H0, ST_EDIT_M1, ST_EDIT_M0: begin
        if (ev_enter) begin
          state_d = ST_COMMIT;
          set_d   = 1'b1;
        end else if (ev_next) begin
          sel_d = sel_q + 2'd1;
          case (state_q)
            ST_EDIT_H1: state_d = ST_EDIT_H0;
            ST_EDIT_H0: state_d = ST_EDIT_M1;
            ST_EDIT_M1: state_d = ST_EDIT_M0;
            default:    state_d = ST_EDIT_H1;
          endcase
        end else if (ev_inc ^ ev_dec) begin
          case (state_q)
            ST_EDIT_H1: begin
              h1_d = step_digit(h1_q, H1_MAX, ev_inc);
              // Moving into the 20s pulls an over-range unit hour down.
              if (h1_d == H1_MAX && h0_q > H0_MAX_20) h0_d = H0_MAX_20;
            end
            ST_EDIT_H0: h0_d = step_digit(h0_q, h0_max, ev_inc);
            ST_EDIT_M1: m1_d = step_digit(m1_q, M1_MAX, ev_inc);
            default:    m0_d = step_digit(m0_q, M0_MAX, ev_inc);
          endcase
        end else if (to_hit) begin
          state_d = ST_IDLE;
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    editing_d = state_d inside {ST_EDIT_H1, ST_EDIT_H0, ST_EDIT_M1, ST_EDIT_M0};
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      h1_q      <= '0;
      h0_q      <= '0;
      m1_q      <= '0;
      m0_q      <= '0;
      set_q     <= 1'b0;
      editing_q <= 1'b0;
      sel_q     <= '0;
    end else begin
      state_q   <= state_d;
      h1_q      <= h1_d;
      h0_q      <= h0_d;
      m1_q      <= m1_d;
      m0_q      <= m0_d;
      set_q     <= set_d;
      editing_q <= editing_d;
      sel_q     <= sel_d;
    end
  end

  assign hour1     = h1_q;
  assign hour0     = h0_q;
  assign minute1   = m1_q;
  assign minute0   = m0_q;
  assign set       = set_q;
  assign editing   = editing_q;
  assign digit_sel = sel_q;

endmodule

// File: tb/tb_time_set_entry.sv
// Self-checking bench for time_set_entry: digit-level behavioural model plus
// directed scenarios with literal expectations.
module tb_time_set_entry;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] btn = 4'b0000;   // {dec, inc, next, enter}
  logic [5:0] cur_hour = 6'd13;
  logic [5:0] cur_minute = 6'd47;
  logic [3:0] hour1, hour0, minute1, minute0;
  logic       set, editing;
  logic [1:0] digit_sel;

  int n_tests = 0;
  int n_fail  = 0;

  time_set_entry #(.TIMEOUT_CYCLES(TO), .TO_W(30)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_enter  (btn[0]),
    .btn_next   (btn[1]),
    .btn_inc    (btn[2]),
    .btn_dec    (btn[3]),
    .cur_hour   (cur_hour),
    .cur_minute (cur_minute),
    .hour1      (hour1),
    .hour0      (hour0),
    .minute1    (minute1),
    .minute0    (minute0),
    .set        (set),
    .editing    (editing),
    .digit_sel  (digit_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0=idle, 1=editing, 2=commit cycle; d[] are the four digits.
  int         d[4] = '{0, 0, 0, 0};
  int         mode = 0;
  int         sel = 0;
  int         tocnt = 0;
  int         mx, hv, mv;
  logic [3:0] pv = 4'b0000;
  logic [3:0] ev;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      d = '{0, 0, 0, 0}; mode = 0; sel = 0; tocnt = 0; pv = 4'b0000;
    end else begin
      ev = btn & ~pv;
      pv = btn;
      if (mode == 0) begin
        if (ev[0]) begin
          hv = (cur_hour > 23) ? 0 : int'(cur_hour);
          mv = (cur_minute > 59) ? 0 : int'(cur_minute);
          d[0] = hv / 10; d[1] = hv % 10; d[2] = mv / 10; d[3] = mv % 10;
          mode = 1; sel = 0; tocnt = 0;
        end
      end else if (mode == 1) begin
        if (ev[0]) mode = 2;
        else if (ev[1]) sel = (sel + 1) % 4;
        else if (ev[2] != ev[3]) begin
          case (sel)
            0: mx = 2;
            1: mx = (d[0] == 2) ? 3 : 9;
            2: mx = 5;
            default: mx = 9;
          endcase
          d[sel] = ev[2] ? (d[sel] + 1) % (mx + 1) : (d[sel] + mx) % (mx + 1);
          if (d[0] == 2 && d[1] > 3) d[1] = 3;
        end
`ifdef SET_TIMEOUT_EN
        if (ev != 4'b0000) tocnt = 0;
        else if (tocnt == TO - 1) begin mode = 0; tocnt = 0; end
        else tocnt++;
`endif
      end else begin
        mode = 0;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    check("model", {12'h0, hour1, hour0, minute1, minute0, set, editing, digit_sel},
          {12'h0, 4'(d[0]), 4'(d[1]), 4'(d[2]), 4'(d[3]),
           (mode == 2), (mode == 1), 2'(sel)});
  end

  task automatic press(input logic [3:0] b);
    @(negedge clk); btn = b;
    @(negedge clk); btn = 4'b0000;
  endtask

  task automatic check_digits(input string name, input logic [15:0] exp);
    check(name, {16'h0, hour1, hour0, minute1, minute0}, {16'h0, exp});
  endtask

  initial begin
    // 1: reset with random buttons
    repeat (4) begin
      @(negedge clk); btn = 4'($urandom_range(0, 15));
      check_digits("reset_digits", 16'h0000);
      check("reset_set", {31'h0, set}, 32'h0);
      check("reset_editing", {31'h0, editing}, 32'h0);
    end
    @(negedge clk); btn = 4'b0000;
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_reset", {31'h0, editing}, 32'h0);

    // 2: preload 13:47
    press(4'b0001);
    check_digits("load_1347", 16'h1347);
    check("load_editing", {31'h0, editing}, 32'h1);
    check("load_sel", {30'h0, digit_sel}, 32'h0);
    press(4'b0001);
    @(negedge clk);

    // out-of-range load gives 00:00
    cur_hour = 6'd30; cur_minute = 6'd61;
    press(4'b0001);
    check_digits("load_oor", 16'h0000);
    press(4'b0001);
    @(negedge clk);

    // 3: hour tens editing from 19:50
    cur_hour = 6'd19; cur_minute = 6'd50;
    press(4'b0001);
    check_digits("load_1950", 16'h1950);
    press(4'b0100);
    check_digits("h1_inc_clamp", 16'h2350);
    press(4'b0100);
    check_digits("h1_inc_wrap", 16'h0350);
    press(4'b1000);
    check_digits("h1_dec_wrap", 16'h2350);
    @(negedge clk); btn = 4'b0100;
    repeat (10) @(negedge clk);
    btn = 4'b0000;
    check_digits("hold_one_step", 16'h0350);

    // 4: minute digits and wrap
    repeat (3) press(4'b0010);
    check("sel_m0", {30'h0, digit_sel}, 32'h3);
    press(4'b1000);
    check_digits("m0_dec_wrap", 16'h0359);
    press(4'b0010);
    check("sel_wrap", {30'h0, digit_sel}, 32'h0);
    repeat (2) press(4'b0010);
    press(4'b0100);
    check_digits("m1_inc_wrap", 16'h0309);
    press(4'b1100);
    check_digits("inc_dec_same", 16'h0309);

    // 5: edit to 23:59 and commit
    repeat (5) press(4'b0100);
    repeat (2) press(4'b0010);
    repeat (2) press(4'b0100);
    check_digits("pre_commit", 16'h2359);
    @(negedge clk); btn = 4'b0001;
    check_digits("commit_before", 16'h2359);
    check("set_before", {31'h0, set}, 32'h0);
    @(negedge clk); btn = 4'b0000;
    check("set_pulse", {31'h0, set}, 32'h1);
    check("commit_editing", {31'h0, editing}, 32'h0);
    check_digits("commit_during", 16'h2359);
    @(negedge clk);
    check("set_after", {31'h0, set}, 32'h0);
    check_digits("commit_after", 16'h2359);
    @(negedge clk);

    // reset during COMMIT
    press(4'b0001);
    press(4'b0001);
    check("set_pulse2", {31'h0, set}, 32'h1);
    #2 rst = 1'b0;
    #1 check("set_async_drop", {31'h0, set}, 32'h0);
    check("editing_async_drop", {31'h0, editing}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("no_pulse_after_reset", {31'h0, set}, 32'h0);

    // 6: timeout behaviour
`ifdef SET_TIMEOUT_EN
    press(4'b0001);
    repeat (TO - 1) @(negedge clk);
    check("to_still_edit", {31'h0, editing}, 32'h1);
    @(negedge clk);
    check("to_abort", {31'h0, editing}, 32'h0);
    check("to_no_set", {31'h0, set}, 32'h0);
    press(4'b0001);
    repeat (9) @(negedge clk);
    press(4'b0100);
    repeat (TO - 1) @(negedge clk);
    check("to_restart_edit", {31'h0, editing}, 32'h1);
    @(negedge clk);
    check("to_restart_abort", {31'h0, editing}, 32'h0);
`else
    press(4'b0001);
    repeat (1000) @(negedge clk);
    check("edit_persists", {31'h0, editing}, 32'h1);
    press(4'b0001);
`endif
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
